// File: rtl/la_vector_mac_pkg.sv
// Shared widths and logic-analyzer bit map for the LA-driven vector MAC.
package la_vector_mac_pkg;
  localparam int DEF_DW = 16;
  localparam int DEF_AW = 40;
  localparam int DEF_CW = 16;
  localparam int LA_W   = 128;

  localparam int A_LSB     = 0;
  localparam int B_LSB     = 16;
  localparam int VALID_BIT = 32;
  localparam int CLEAR_BIT = 33;
  localparam int LAST_BIT  = 34;

  localparam int ACC_LSB  = 0;
  localparam int DONE_BIT = 40;
  localparam int BUSY_BIT = 41;
  localparam int OVF_BIT  = 42;
  localparam int CNT_LSB  = 48;
endpackage

// File: rtl/la_edge_detect.sv
// Rising-edge detector: fires the cycle the input is high after a low sample.
module la_edge_detect (
  input  logic gclk,
  input  logic grst_n,
  input  logic sig,
  output logic rise
);
  logic prev;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) prev <= 1'b0;
    else         prev <= sig;
  end

  assign rise = sig & ~prev;
endmodule

// File: rtl/la_vector_mac_unit.sv
// Signed dot-product accumulator fed over the LA bus: capture, multiply, accumulate.
module la_vector_mac_unit
  import la_vector_mac_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic            wb_clk_i,
  input  logic            rst_n,
  input  logic [LA_W-1:0] la_data_in,
  input  logic [LA_W-1:0] la_oenb,
  output logic [LA_W-1:0] la_data_out,
  output logic            irq
);
  localparam int STAGES = 1;
  localparam int PW     = 2 * DW;

  logic [LA_W-1:0] g;
  logic [1:0]      ed_in, ed_rise;
  logic            vld_rise, clr_rise;

  assign g     = la_data_in & ~la_oenb;
  assign ed_in = {g[CLEAR_BIT], g[VALID_BIT]};

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_edge
      la_edge_detect u_edge (
        .gclk  (wb_clk_i),
        .grst_n(rst_n),
        .sig   (ed_in[i]),
        .rise  (ed_rise[i])
      );
    end
  endgenerate

  assign vld_rise = ed_rise[0];
  assign clr_rise = ed_rise[1];

  logic [STAGES:0]      vld_pipe;
  logic signed [DW-1:0] a_q, b_q;
  logic                 last_q, last_p;
  logic signed [PW-1:0] prod_q;
  logic [AW-1:0]        acc, prod_ext, sum;
  logic [CW-1:0]        count;
  logic                 done, ovf, sum_ovf;

  assign prod_ext = {{(AW-PW){prod_q[PW-1]}}, prod_q};
  assign sum      = acc + prod_ext;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign sum_ovf  = (acc[AW-1] == prod_ext[AW-1]) && (sum[AW-1] != acc[AW-1]);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      last_q   <= 1'b0;
      last_p   <= 1'b0;
      prod_q   <= '0;
      acc      <= '0;
      count    <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      irq      <= 1'b0;
    end else if (clr_rise) begin
      // Clear outranks a coincident valid edge and flushes in-flight elements.
      vld_pipe <= '0;
      acc      <= '0;
      count    <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      irq      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], vld_rise};
      irq      <= 1'b0;
      if (vld_rise) begin
        a_q    <= $signed(g[A_LSB +: DW]);
        b_q    <= $signed(g[B_LSB +: DW]);
        last_q <= g[LAST_BIT];
        if (done) done <= 1'b0;
      end
      if (vld_pipe[0]) begin
        prod_q <= a_q * b_q;
        last_p <= last_q;
      end
      // A landing last element wins over a new edge clearing done in the same cycle.
      if (vld_pipe[STAGES]) begin
        acc <= sum;
        if (count != '1) count <= count + 1'b1;
        if (sum_ovf) ovf <= 1'b1;
        if (last_p) begin
          done <= 1'b1;
          irq  <= ~done;
        end
      end
    end
  end

  always_comb begin
    la_data_out                   = '0;
    la_data_out[ACC_LSB +: AW]    = acc;
    la_data_out[DONE_BIT]         = done;
    la_data_out[BUSY_BIT]         = |vld_pipe;
    la_data_out[OVF_BIT]          = ovf;
    la_data_out[CNT_LSB +: CW]    = count;
  end

  logic unused_la;
  assign unused_la = ^{g[LA_W-1:LAST_BIT+1]};
endmodule

// File: tb/tb_la_vector_mac_unit.sv
// Directed bench for la_vector_mac_unit with hand-computed expected values.
module tb_la_vector_mac_unit;
  logic         wb_clk_i = 1'b0;
  logic         rst_n;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic         irq;

  int n_chk  = 0;
  int n_pass = 0;
  int irq_cnt = 0;

  la_vector_mac_unit dut (
    .wb_clk_i   (wb_clk_i),
    .rst_n      (rst_n),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .irq        (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) if (irq) irq_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic l);
    la_data_in[15:0]  = a;
    la_data_in[31:16] = b;
    la_data_in[34]    = l;
    la_data_in[32]    = 1'b1;
    @(negedge wb_clk_i);
    la_data_in[32] = 1'b0;
    la_data_in[34] = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic do_clear();
    la_data_in[33] = 1'b1;
    @(negedge wb_clk_i);
    la_data_in[33] = 1'b0;
    @(negedge wb_clk_i);
  endtask

  function automatic logic [63:0] acc_o();  return {24'd0, la_data_out[39:0]}; endfunction
  function automatic logic [63:0] cnt_o();  return {48'd0, la_data_out[63:48]}; endfunction
  function automatic logic [63:0] bit_o(input int b); return {63'd0, la_data_out[b]}; endfunction

  initial begin
    rst_n      = 1'b0;
    la_data_in = '0;
    la_oenb    = '0;
    repeat (2) @(negedge wb_clk_i);
    chk("rst_out",  {63'd0, |la_data_out}, 64'd0);
    chk("rst_irq",  {63'd0, irq}, 64'd0);
    rst_n = 1'b1;
    @(negedge wb_clk_i);

    // Dot product 1*5+2*6+3*7+4*8 = 70
    push(16'd1, 16'd5, 1'b0);
    push(16'd2, 16'd6, 1'b0);
    push(16'd3, 16'd7, 1'b0);
    push(16'd4, 16'd8, 1'b1);
    chk("dot_busy_mid", bit_o(41), 64'd1);
    @(negedge wb_clk_i);
    chk("dot_acc",   acc_o(), 64'd70);
    chk("dot_cnt",   cnt_o(), 64'd4);
    chk("dot_done",  bit_o(40), 64'd1);
    chk("dot_ovf",   bit_o(42), 64'd0);
    chk("dot_busy",  bit_o(41), 64'd0);
    chk("dot_irq",   {63'd0, irq}, 64'd1);
    chk("dot_pad",   {16'd0, la_data_out[47:43], la_data_out[127:85]}, 64'd0);
    chk("dot_hi",    la_data_out[127:64], 64'd0);
    @(negedge wb_clk_i);
    chk("dot_irq_off", {63'd0, irq}, 64'd0);
    chk("dot_irq_cnt", irq_cnt, 64'd1);

    // New element after done: clears done, accumulates on top
    push(16'd1, 16'd1, 1'b0);
    @(negedge wb_clk_i);
    chk("more_acc",  acc_o(), 64'd71);
    chk("more_cnt",  cnt_o(), 64'd5);
    chk("more_done", bit_o(40), 64'd0);

    do_clear();
    chk("clr_acc",  acc_o(), 64'd0);
    chk("clr_cnt",  cnt_o(), 64'd0);

    // Signed: -3 * 7 = -21
    push(16'hFFFD, 16'd7, 1'b1);
    @(negedge wb_clk_i);
    chk("sgn_acc",  acc_o(), 64'h00FF_FFFF_FFEB);
    chk("sgn_cnt",  cnt_o(), 64'd1);
    chk("sgn_done", bit_o(40), 64'd1);

    // Clear and valid rising together: clear wins, element discarded
    la_data_in[15:0]  = 16'd2;
    la_data_in[31:16] = 16'd2;
    la_data_in[33:32] = 2'b11;
    @(negedge wb_clk_i);
    la_data_in[33:32] = 2'b00;
    repeat (3) @(negedge wb_clk_i);
    chk("pri_acc",  acc_o(), 64'd0);
    chk("pri_cnt",  cnt_o(), 64'd0);
    chk("pri_done", bit_o(40), 64'd0);

    // Gated valid is ignored
    la_oenb[32] = 1'b1;
    push(16'd3, 16'd3, 1'b0);
    @(negedge wb_clk_i);
    la_oenb[32] = 1'b0;
    @(negedge wb_clk_i);
    chk("gate_acc", acc_o(), 64'd0);
    chk("gate_cnt", cnt_o(), 64'd0);

    // Level hold yields exactly one element: 5 * -2 = -10
    la_data_in[15:0]  = 16'd5;
    la_data_in[31:16] = 16'hFFFE;
    la_data_in[32]    = 1'b1;
    repeat (10) @(negedge wb_clk_i);
    la_data_in[32] = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    chk("hold_cnt", cnt_o(), 64'd1);
    chk("hold_acc", acc_o(), 64'h00FF_FFFF_FFF6);

    // Overflow: 0x7FFF^2 = 0x3FFF0001; 512 of them fit, 513 overflow
    do_clear();
    repeat (512) push(16'h7FFF, 16'h7FFF, 1'b0);
    @(negedge wb_clk_i);
    chk("ovf512_ovf", bit_o(42), 64'd0);
    chk("ovf512_acc", acc_o(), 64'h0000_007F_FE00_0200);
    chk("ovf512_cnt", cnt_o(), 64'd512);
    push(16'h7FFF, 16'h7FFF, 1'b0);
    @(negedge wb_clk_i);
    chk("ovf513_ovf", bit_o(42), 64'd1);
    chk("ovf513_acc", acc_o(), 64'h0000_0080_3DFF_0201);
    chk("ovf513_cnt", cnt_o(), 64'd513);
    chk("ovf513_neg", bit_o(39), 64'd1);
    push(16'd1, 16'd1, 1'b0);
    @(negedge wb_clk_i);
    chk("ovf_sticky", bit_o(42), 64'd1);

    // Async reset one cycle after a valid edge
    la_data_in[15:0]  = 16'd3;
    la_data_in[31:16] = 16'd3;
    la_data_in[32]    = 1'b1;
    @(negedge wb_clk_i);
    rst_n = 1'b0;
    #1;
    chk("arst_out", {63'd0, |la_data_out}, 64'd0);
    chk("arst_irq", {63'd0, irq}, 64'd0);
    @(negedge wb_clk_i);
    la_data_in[32] = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    chk("arst_acc",  acc_o(), 64'd0);
    chk("arst_cnt",  cnt_o(), 64'd0);
    chk("arst_busy", bit_o(41), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/la_vector_mac_unit.md
Name: la_vector_mac_unit

Overview:
- User-project vector multiply-accumulate unit driven entirely through the Caravel logic-analyzer (LA) bus.
- Management firmware streams signed operand pairs on LA inputs; the block accumulates their dot product and reports result, element count and status on LA outputs.
- Firmware signals test start/pass on GPIO checkbits 0xAB40 / 0xAB41; that signalling is firmware-side, not part of this block.

Parameters:
- DW, 16, operand width (signed two's complement).
- AW, 40, accumulator width (signed, DW*2+8).
- CW, 16, element-counter width.

Ports:
- wb_clk_i  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- la_data_in  in  128  LA bits from management SoC.
- la_oenb  in  128  LA output-enable-bar; an LA input bit is honoured only when its la_oenb bit is 0, otherwise it reads as 0.
- la_data_out  out  128  LA bits to management SoC.
- irq  out  1  one-cycle pulse when done rises.

Behaviour:
- Input map (after oenb gating):
  - [15:0] A.
  - [31:16] B.
  - [32] valid.
  - [33] clear.
  - [34] last.
- Output map:
  - [39:0] acc.
  - [40] done.
  - [41] busy.
  - [42] ovf (sticky).
  - [47:43] 0.
  - [63:48] count.
  - [127:64] 0.
- Reset: acc, count, done, busy, ovf, irq, pipeline valids and edge-detect registers all 0; la_data_out all 0.
- valid and clear are edge-detected. A rising edge is seen when the gated bit is 1 at posedge t and was 0 at posedge t-1. Level holds never repeat an action.
- Pipeline for a valid edge at posedge t:
  - t: A, B and last are captured.
  - t+1: signed product P = A*B (2*DW bits) is registered.
  - t+2: acc <= acc + sign_extend(P), modulo 2^AW; count increments, saturating at 2^CW-1.
- busy = 1 from t through t+2 while any element is in flight.
- ovf sets when an addition overflows in the signed sense (operands same sign, result sign differs). It clears only on clear or reset.
- done sets at t+2 of an element tagged last. irq pulses the same cycle.
- A valid edge while done=1 clears done and accumulates on top of the current acc.
- clear edge: acc, count, done and ovf go to 0, and in-flight pipeline stages are flushed, all on the next posedge.
- clear and valid edges in the same cycle: clear wins; the element is discarded.
- Back-to-back valid edges are at most one per 2 cycles (the edge rule enforces this). The pipeline accepts one element per cycle with no stall.
- Asynchronous reset mid-operation discards all in-flight data immediately.

Decomposition:
- Shared package holds DW, AW and CW defaults plus localparam LA bit indices:
  - A_LSB=0, B_LSB=16, VALID_BIT=32, CLEAR_BIT=33, LAST_BIT=34.
  - ACC_LSB=0, DONE_BIT=40, BUSY_BIT=41, OVF_BIT=42, CNT_LSB=48.
- One natural sub-module, la_edge_detect, instantiated for valid and clear.
- Datapath (multiply, accumulate, overflow) stays in the top.

Test Plan:
- Dot product: pairs (1,5),(2,6),(3,7),(4,8), last on the 4th → acc=70 (0x46), count=4, done=1, irq one pulse, ovf=0, busy=0 two cycles after the last edge.
- Signed: clear, then A=-3 (0xFFFD), B=7, last → acc=0xFF_FFFF_FFEB, count=1, done=1.
- Overflow: clear, then 513 pairs (0x7FFF,0x7FFF) → ovf=0 after element 512, ovf=1 after element 513, count=513, acc wrapped negative.
- Priority and gating:
  - clear and valid rising the same cycle → acc=0, count=0.
  - valid toggled with la_oenb[32]=1 → no accumulation.
  - valid held high 10 cycles → exactly one element.
- Reset: assert rst_n=0 one cycle after a valid edge → all outputs 0 immediately; after release the element never lands (acc=0, count=0).
